// File: rtl/hazard_md_scheduler.sv
// rtl/hazard_md_scheduler.sv - D-stage hazard, forwarding-select and mult/div sequencing
//
// Tracks the destination register and remaining Tnew of the instructions in E/M/W.
// From these it drives the D-stage forwarding selects and the global pipeline stall.
// It also sequences the multiply/divide unit: issue pulse, busy countdown, and stall
// of any HI/LO user while that unit is busy.
//
// Ports:
//   CLK, Reset        clock (rising edge), synchronous active-high clear
//   RS_D, RT_D        source register fields of the D instruction
//   TuseRS_D/RT_D     cycles until each operand is consumed (3 = operand unused)
//   Dst_D, TnewE_D    destination of the D instruction and its Tnew once in E
//   MDStart_D         D instruction is mult/multu/div/divu
//   MDIsDiv_D         marks that start as a divide
//   MDUse_D           D instruction touches the mult/div unit or HI/LO
//   Stall             freeze PC and D register, bubble into E
//   ForwardRSD/RTD    0 register file, 1 W write data, 2 M ALU output
//   MDStart_E         one-cycle start pulse, aligned with the instruction in E
//   MDBusy            mult/div countdown still running
module hazard_md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [4:0] RS_D,
  input  logic [4:0] RT_D,
  input  logic [1:0] TuseRS_D,
  input  logic [1:0] TuseRT_D,
  input  logic [4:0] Dst_D,
  input  logic [1:0] TnewE_D,
  input  logic       MDStart_D,
  input  logic       MDIsDiv_D,
  input  logic       MDUse_D,
  output logic       Stall,
  output logic [1:0] ForwardRSD,
  output logic [1:0] ForwardRTD,
  output logic       MDStart_E,
  output logic       MDBusy
);

  logic [4:0] e_dst, m_dst, w_dst;
  logic [1:0] e_tnew, m_tnew;
  logic       e_md, e_div;
  logic [5:0] md_cnt;

  logic stall_rs, stall_rt, stall_md;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      e_dst  <= '0;
      e_tnew <= '0;
      e_md   <= 1'b0;
      e_div  <= 1'b0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_dst  <= '0;
      md_cnt <= '0;
    end else begin
      if (Stall) begin
        e_dst  <= '0;
        e_tnew <= '0;
        e_md   <= 1'b0;
        e_div  <= 1'b0;
      end else begin
        e_dst  <= Dst_D;
        e_tnew <= TnewE_D;
        e_md   <= MDStart_D;
        e_div  <= MDIsDiv_D;
      end
      m_dst  <= e_dst;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      w_dst  <= m_dst;
      // A fresh issue in E always wins over the running countdown.
      if (e_md)
        md_cnt <= e_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
      else if (md_cnt != 6'd0)
        md_cnt <= md_cnt - 6'd1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (src == 5'd0)
      return 2'd0;
    else if (src == m_dst && m_tnew == 2'd0)
      return 2'd2;
    else if (src == w_dst)
      return 2'd1;
    else
      return 2'd0;
  endfunction

  // The D-stage mux has no E-stage input, so a zero-Tuse consumer must stall on any E
  // producer even if its result is already available there.
  function automatic logic data_stall(input logic [4:0] src, input logic [1:0] tuse);
    logic hit_e, hit_m;
    hit_e = (src == e_dst) && ((e_tnew > tuse) || (tuse == 2'd0));
    hit_m = (src == m_dst) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
  endfunction

  always_comb begin
    ForwardRSD = fwd_sel(RS_D);
    ForwardRTD = fwd_sel(RT_D);
    stall_rs   = data_stall(RS_D, TuseRS_D);
    stall_rt   = data_stall(RT_D, TuseRT_D);
    MDBusy     = (md_cnt != 6'd0);
    stall_md   = MDUse_D && (MDBusy || e_md);
    Stall      = stall_rs || stall_rt || stall_md;
    MDStart_E  = e_md;
  end

endmodule

// File: tb/tb_hazard_md_scheduler.sv
// tb/tb_hazard_md_scheduler.sv - directed-vector bench for hazard_md_scheduler
module tb_hazard_md_scheduler;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [4:0] RS_D, RT_D, Dst_D;
  logic [1:0] TuseRS_D, TuseRT_D, TnewE_D;
  logic       MDStart_D, MDIsDiv_D, MDUse_D;
  logic       Stall, MDStart_E, MDBusy;
  logic [1:0] ForwardRSD, ForwardRTD;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .Reset(Reset),
    .RS_D(RS_D), .RT_D(RT_D), .TuseRS_D(TuseRS_D), .TuseRT_D(TuseRT_D),
    .Dst_D(Dst_D), .TnewE_D(TnewE_D),
    .MDStart_D(MDStart_D), .MDIsDiv_D(MDIsDiv_D), .MDUse_D(MDUse_D),
    .Stall(Stall), .ForwardRSD(ForwardRSD), .ForwardRTD(ForwardRTD),
    .MDStart_E(MDStart_E), .MDBusy(MDBusy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // D-stage instruction: rs, rt, TuseRS, TuseRT, Dst, TnewE, MDStart, MDIsDiv, MDUse
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic md, input logic dv, input logic use_md);
    RS_D = rs; RT_D = rt; TuseRS_D = trs; TuseRT_D = trt;
    Dst_D = dst; TnewE_D = tn; MDStart_D = md; MDIsDiv_D = dv; MDUse_D = use_md;
    #2;
  endtask

  task automatic nop();
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1;
    nop();
    tick();
    tick();
    drive(5, 6, 1, 1, 0, 0, 0, 0, 1);
    check("rst_stall", Stall, 0);
    check("rst_fwd_rs", ForwardRSD, 0);
    check("rst_fwd_rt", ForwardRTD, 0);
    check("rst_mdstart", MDStart_E, 0);
    check("rst_busy", MDBusy, 0);
    Reset = 1'b0;
    flush(1);

    // lw $1 ; beq $1,$2 : two stall cycles, then forward from W
    drive(0, 0, 1, 3, 1, 2, 0, 0, 0);
    check("lw_nostall", Stall, 0);
    tick();
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    check("lwbeq_stall1", Stall, 1);
    tick();
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    check("lwbeq_stall2", Stall, 1);
    tick();
    drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    check("lwbeq_release", Stall, 0);
    check("lwbeq_fwd_rs", ForwardRSD, 1);
    check("lwbeq_fwd_rt", ForwardRTD, 0);
    tick();
    flush(3);

    // addu $3 ; addu $4,$3 : Tnew equals Tuse, no stall, no D-stage forward
    drive(5, 6, 1, 1, 3, 1, 0, 0, 0);
    tick();
    drive(3, 7, 1, 1, 4, 1, 0, 0, 0);
    check("alu_adj_stall", Stall, 0);
    check("alu_adj_fwd", ForwardRSD, 0);
    tick();
    flush(3);

    // addu $3 ; nop ; beq $3,$3 : forward from M on both operands
    drive(5, 6, 1, 1, 3, 1, 0, 0, 0);
    tick();
    nop();
    tick();
    drive(3, 3, 0, 0, 0, 0, 0, 0, 0);
    check("alu_m_stall", Stall, 0);
    check("alu_m_fwd_rs", ForwardRSD, 2);
    check("alu_m_fwd_rt", ForwardRTD, 2);
    tick();
    flush(3);

    // addu $8 ; addu $8 ; nop ; use $8 : M beats W
    drive(5, 6, 1, 1, 8, 1, 0, 0, 0);
    tick();
    drive(5, 6, 1, 1, 8, 1, 0, 0, 0);
    tick();
    nop();
    tick();
    drive(8, 0, 1, 3, 9, 1, 0, 0, 0);
    check("m_over_w", ForwardRSD, 2);
    tick();
    flush(3);

    // lw $21 ; consumer that marks rs unused : no stall
    drive(0, 0, 1, 3, 21, 2, 0, 0, 0);
    tick();
    drive(21, 0, 3, 3, 0, 0, 0, 0, 0);
    check("tuse3_nostall", Stall, 0);
    tick();
    flush(3);

    // jal ($31, Tnew 0) ; jr $31 : E producer with Tuse 0 still stalls
    drive(0, 0, 3, 3, 31, 0, 0, 0, 0);
    tick();
    drive(31, 0, 0, 3, 0, 0, 0, 0, 0);
    check("jal_jr_stall", Stall, 1);
    tick();
    drive(31, 0, 0, 3, 0, 0, 0, 0, 0);
    check("jal_jr_release", Stall, 0);
    check("jal_jr_fwd", ForwardRSD, 2);
    tick();
    flush(3);

    // mult ; mflo : start pulse once, stall 6 cycles
    drive(9, 10, 1, 1, 0, 0, 1, 0, 1);
    check("mult_issue_stall", Stall, 0);
    check("mult_pre_pulse", MDStart_E, 0);
    tick();
    drive(0, 0, 3, 3, 11, 1, 0, 0, 1);
    check("mult_pulse", MDStart_E, 1);
    check("mflo_stall_e", Stall, 1);
    check("mult_busy_c1", MDBusy, 0);
    tick();
    check("mult_pulse_once", MDStart_E, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mflo_stall_%0d", i + 2), Stall, 1);
      check($sformatf("mult_busy_%0d", i + 2), MDBusy, 1);
      tick();
    end
    check("mflo_release", Stall, 0);
    check("mult_idle", MDBusy, 0);
    tick();
    flush(3);

    // div ; 3 ALU ops ; mfhi : busy 10 cycles, mfhi stalls until counter reaches 0
    drive(9, 10, 1, 1, 0, 0, 1, 1, 1);
    tick();
    drive(0, 0, 3, 3, 12, 1, 0, 0, 0);
    check("div_pulse", MDStart_E, 1);
    check("div_busy_c1", MDBusy, 0);
    check("div_alu1_stall", Stall, 0);
    tick();
    drive(0, 0, 3, 3, 13, 1, 0, 0, 0);
    check("div_busy_c2", MDBusy, 1);
    check("div_alu2_stall", Stall, 0);
    tick();
    drive(0, 0, 3, 3, 14, 1, 0, 0, 0);
    check("div_alu3_stall", Stall, 0);
    tick();
    drive(0, 0, 3, 3, 15, 1, 0, 0, 1);
    for (int c = 4; c < 12; c++) begin
      check($sformatf("mfhi_stall_c%0d", c), Stall, 1);
      check($sformatf("div_busy_c%0d", c), MDBusy, 1);
      tick();
    end
    check("mfhi_release", Stall, 0);
    check("div_idle", MDBusy, 0);
    tick();
    flush(3);

    // Reset with counter at 4 clears the countdown and all tracking
    drive(9, 10, 1, 1, 0, 0, 1, 0, 1);
    tick();
    drive(0, 0, 3, 3, 20, 1, 0, 0, 0);
    tick();
    nop();
    tick();
    nop();
    check("pre_reset_busy", MDBusy, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(20, 0, 1, 3, 0, 0, 0, 0, 1);
    check("post_reset_busy", MDBusy, 0);
    check("post_reset_stall", Stall, 0);
    check("post_reset_fwd_rs", ForwardRSD, 0);
    check("post_reset_fwd_rt", ForwardRTD, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
